// File: rtl/fifo_mc_if.sv
// fifo_mc_if: push/pop/flush bundle and per-channel status for fifo_mc.
// Carries err_r only when FIFO_MC_ERR_EN is defined.
interface fifo_mc_if #(
  parameter int W = 32,
  parameter int N = 16,
  parameter int C = 4
);
  logic                           push;
  logic [$clog2(C)-1:0]           push_ch;
  logic [W-1:0]                   push_data;
  logic                           pop;
  logic [$clog2(C)-1:0]           pop_ch;
  logic [W-1:0]                   pop_data;
  logic [C-1:0]                   flush;
  logic [C-1:0]                   empty_r;
  logic [C-1:0]                   full_r;
  logic [C-1:0]                   afull_r;
  logic [C*($clog2(N)+1)-1:0]     level_r;
`ifdef FIFO_MC_ERR_EN
  logic [C-1:0]                   err_r;
  modport master (output push, push_ch, push_data, pop, pop_ch, flush,
                  input pop_data, empty_r, full_r, afull_r, level_r, err_r);
  modport slave  (input push, push_ch, push_data, pop, pop_ch, flush,
                  output pop_data, empty_r, full_r, afull_r, level_r, err_r);
`else
  modport master (output push, push_ch, push_data, pop, pop_ch, flush,
                  input pop_data, empty_r, full_r, afull_r, level_r);
  modport slave  (input push, push_ch, push_data, pop, pop_ch, flush,
                  output pop_data, empty_r, full_r, afull_r, level_r);
`endif
endinterface

// File: rtl/fifo_mc.sv
// fifo_mc: C independent FIFOs of N x W words partitioned out of one flat array.
// Define FIFO_MC_ERR_EN to add the sticky per-channel illegal-use flag err_r.
module fifo_mc #(
  parameter int W = 32,
  parameter int N = 16,
  parameter int C = 4,
  parameter int AFULL_TH = 14
) (
  input  logic     clk,
  input  logic     rst,
  fifo_mc_if.slave bus
);
  localparam int CW = $clog2(C);
  localparam int AW = $clog2(N);
  localparam int PW = AW + 1;
  if (N < 2 || (N & (N - 1)) != 0) begin : g_chk_n
    $error("fifo_mc: N must be a power of 2 >= 2");
  end
  if (C < 2 || (C & (C - 1)) != 0) begin : g_chk_c
    $error("fifo_mc: C must be a power of 2 >= 2");
  end
  if (AFULL_TH < 1 || AFULL_TH > N) begin : g_chk_th
    $error("fifo_mc: AFULL_TH must be in 1..N");
  end
  logic [W-1:0]    r_mem [C*N];
  logic [PW-1:0]   r_rd [C];
  logic [PW-1:0]   r_wr [C];
  logic [PW-1:0]   w_rd_nx [C];
  logic [PW-1:0]   w_wr_nx [C];
  logic [PW-1:0]   w_lvl [C];
  logic [C-1:0]    r_empty, r_full, r_afull;
  logic [C*PW-1:0] r_level;
  logic            w_push_adv, w_pop_adv;
  assign w_push_adv = bus.push & ~r_full[bus.push_ch] & ~bus.flush[bus.push_ch];
  assign w_pop_adv  = bus.pop & ~r_empty[bus.pop_ch] & ~bus.flush[bus.pop_ch];
  always_comb begin
    for (int c = 0; c < C; c++) begin
      w_rd_nx[c] = bus.flush[c] ? '0 : r_rd[c] + PW'(w_pop_adv && bus.pop_ch == CW'(c));
      w_wr_nx[c] = bus.flush[c] ? '0 : r_wr[c] + PW'(w_push_adv && bus.push_ch == CW'(c));
      w_lvl[c]   = w_wr_nx[c] - w_rd_nx[c];
    end
  end
  // Flags come from next-state pointers so they are valid the cycle after the accepting edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < C; c++) begin
        r_rd[c] <= '0;
        r_wr[c] <= '0;
      end
      r_empty <= '1;
      r_full  <= '0;
      r_afull <= '0;
      r_level <= '0;
    end else begin
      for (int c = 0; c < C; c++) begin
        r_rd[c]              <= w_rd_nx[c];
        r_wr[c]              <= w_wr_nx[c];
        r_empty[c]           <= w_rd_nx[c] == w_wr_nx[c];
        r_full[c]            <= w_rd_nx[c][AW] != w_wr_nx[c][AW] && w_rd_nx[c][AW-1:0] == w_wr_nx[c][AW-1:0];
        r_afull[c]           <= w_lvl[c] >= PW'(AFULL_TH);
        r_level[c*PW +: PW]  <= w_lvl[c];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (w_push_adv) r_mem[{bus.push_ch, r_wr[bus.push_ch][AW-1:0]}] <= bus.push_data;
  end
  assign bus.pop_data = r_mem[{bus.pop_ch, r_rd[bus.pop_ch][AW-1:0]}];
  assign bus.empty_r  = r_empty;
  assign bus.full_r   = r_full;
  assign bus.afull_r  = r_afull;
  assign bus.level_r  = r_level;
`ifdef FIFO_MC_ERR_EN
  logic [C-1:0] r_err;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_err <= '0;
    else for (int c = 0; c < C; c++)
      r_err[c] <= ~bus.flush[c] & (r_err[c] | (bus.push & bus.push_ch == CW'(c) & r_full[c])
                                            | (bus.pop & bus.pop_ch == CW'(c) & r_empty[c]));
  end
  assign bus.err_r = r_err;
`endif
  always @(posedge clk) begin
    if (!rst) assert ((r_empty & r_full) == '0);
  end
endmodule

// File: tb/tb_fifo_mc.sv
// tb_fifo_mc: randomized and directed checks of fifo_mc against per-channel queue models.
module tb_fifo_mc;
  localparam int W = 32, N = 16, C = 4, TH = 14;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  fifo_mc_if #(.W(W), .N(N), .C(C)) bus();
  fifo_mc #(.W(W), .N(N), .C(C), .AFULL_TH(TH)) dut (.clk(clk), .rst(rst), .bus(bus));
  logic [31:0] q [C][$];
  logic [3:0]  m_err = '0;
  int          vec = 0, miss = 0;
  bit          pop_ok;
  logic [31:0] got_pop, exp_pop;
  function automatic logic [31:0] exp_state();
    logic [31:0] s;
    s = '0;
    for (int c = 0; c < C; c++) begin
      s[28+c]     = q[c].size() == 0;
      s[24+c]     = q[c].size() == N;
      s[20+c]     = q[c].size() >= TH;
      s[c*5 +: 5] = 5'(q[c].size());
    end
    return s;
  endfunction
  task automatic cycle(input logic pu, input logic [1:0] pc, input logic [31:0] pd,
                       input logic po, input logic [1:0] oc, input logic [3:0] fl);
    bit pa, oa;
    bus.push = pu; bus.push_ch = pc; bus.push_data = pd;
    bus.pop = po; bus.pop_ch = oc; bus.flush = fl;
    #1;
    pa = pu && q[pc].size() < N && !fl[pc];
    oa = po && q[oc].size() != 0 && !fl[oc];
    pop_ok = oa;
    got_pop = bus.pop_data;
    if (oa) exp_pop = q[oc][0];
    for (int c = 0; c < C; c++) begin
      if (fl[c]) m_err[c] = 0;
      else if ((pu && pc == 2'(c) && q[c].size() == N) || (po && oc == 2'(c) && q[c].size() == 0)) m_err[c] = 1;
    end
    for (int c = 0; c < C; c++) if (fl[c]) q[c].delete();
    if (oa) void'(q[oc].pop_front());
    if (pa) q[pc].push_back(pd);
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0);
  endtask
  task automatic test_reset();
    bus.push = 0; bus.push_ch = 0; bus.push_data = 0; bus.pop = 0; bus.pop_ch = 0; bus.flush = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    idle();
    vec++;
    if ({bus.empty_r, bus.full_r, bus.afull_r, bus.level_r} !== 32'hF000_0000) begin
      miss++; $display("FAIL reset_state got=%h exp=%h", {bus.empty_r, bus.full_r, bus.afull_r, bus.level_r}, 32'hF000_0000);
    end
  endtask
  task automatic test_fill_drain();
    for (int i = 0; i < N; i++) begin
      cycle(1, 2, 32'h100 + i, 0, 0, 0);
      vec++;
      if ({bus.empty_r, bus.full_r, bus.afull_r, bus.level_r} !== exp_state()) begin
        miss++; $display("FAIL fill_state i=%0d got=%h exp=%h", i, {bus.empty_r, bus.full_r, bus.afull_r, bus.level_r}, exp_state());
      end
      vec++;
      if (bus.afull_r[2] !== (i >= TH - 1)) begin
        miss++; $display("FAIL fill_afull i=%0d got=%b exp=%b", i, bus.afull_r[2], i >= TH - 1);
      end
    end
    cycle(1, 2, 32'hDEAD, 0, 0, 0);
    vec++;
    if (bus.level_r[14:10] !== 5'd16 || bus.full_r !== 4'b0100) begin
      miss++; $display("FAIL full_push level=%0d full=%b exp=16/0100", bus.level_r[14:10], bus.full_r);
    end
    for (int i = 0; i < N; i++) begin
      cycle(0, 0, 0, 1, 2, 0);
      vec++;
      if (!pop_ok || got_pop !== 32'h100 + i) begin
        miss++; $display("FAIL drain_data i=%0d got=%h exp=%h", i, got_pop, 32'h100 + i);
      end
    end
    vec++;
    if ({bus.empty_r, bus.full_r, bus.afull_r, bus.level_r} !== 32'hF000_0000) begin
      miss++; $display("FAIL drain_state got=%h exp=%h", {bus.empty_r, bus.full_r, bus.afull_r, bus.level_r}, 32'hF000_0000);
    end
  endtask
  task automatic test_interleave();
    for (int i = 0; i < 8; i++) cycle(1, (i % 2) ? 2'd3 : 2'd0, (i % 2) ? 32'hB0 + i / 2 : 32'hA0 + i / 2, 1, 1, 0);
    vec++;
    if ({bus.empty_r, bus.full_r, bus.afull_r, bus.level_r} !== exp_state() || bus.level_r[9:5] !== 5'd0) begin
      miss++; $display("FAIL interleave_state got=%h exp=%h", {bus.empty_r, bus.full_r, bus.afull_r, bus.level_r}, exp_state());
    end
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, 1, 0, 0);
      vec++;
      if (got_pop !== 32'hA0 + i) begin miss++; $display("FAIL interleave_ch0 i=%0d got=%h exp=%h", i, got_pop, 32'hA0 + i); end
      cycle(0, 0, 0, 1, 3, 0);
      vec++;
      if (got_pop !== 32'hB0 + i) begin miss++; $display("FAIL interleave_ch3 i=%0d got=%h exp=%h", i, got_pop, 32'hB0 + i); end
    end
  endtask
  task automatic test_same_cycle();
    for (int i = 0; i < 5; i++) cycle(1, 1, $urandom, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      cycle(1, 1, $urandom, 1, 1, 0);
      vec++;
      if (!pop_ok || got_pop !== exp_pop || bus.level_r[9:5] !== 5'd5) begin
        miss++; $display("FAIL same_cycle i=%0d data=%h exp=%h level=%0d exp=5", i, got_pop, exp_pop, bus.level_r[9:5]);
      end
    end
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0, 1, 1, 0);
      vec++;
      if (got_pop !== exp_pop) begin miss++; $display("FAIL same_drain i=%0d got=%h exp=%h", i, got_pop, exp_pop); end
    end
  endtask
  task automatic test_flush();
    for (int i = 0; i < 8; i++) cycle(1, 0, 32'hC0 + i, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, 3, 32'hD0 + i, 0, 0, 0);
    cycle(1, 0, 32'hEEEE, 1, 3, 4'b0001);
    vec++;
    if (!pop_ok || got_pop !== 32'hD0) begin miss++; $display("FAIL flush_pop got=%h exp=%h", got_pop, 32'hD0); end
    vec++;
    if (bus.empty_r[0] !== 1'b1 || bus.level_r[4:0] !== 5'd0 || bus.level_r[19:15] !== 5'd2) begin
      miss++; $display("FAIL flush_state empty0=%b lvl0=%0d lvl3=%0d exp=1/0/2", bus.empty_r[0], bus.level_r[4:0], bus.level_r[19:15]);
    end
    cycle(0, 0, 0, 0, 0, 4'hF);
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, 2'($urandom), $urandom, $urandom_range(0, 2) != 0, 2'($urandom),
            ($urandom_range(0, 29) == 0) ? 4'($urandom) : 4'h0);
      vec++;
      if (pop_ok && got_pop !== exp_pop) begin miss++; $display("FAIL rand_pop i=%0d got=%h exp=%h", i, got_pop, exp_pop); end
      vec++;
      if ({bus.empty_r, bus.full_r, bus.afull_r, bus.level_r} !== exp_state()) begin
        miss++; $display("FAIL rand_state i=%0d got=%h exp=%h", i, {bus.empty_r, bus.full_r, bus.afull_r, bus.level_r}, exp_state());
      end
`ifdef FIFO_MC_ERR_EN
      vec++;
      if (bus.err_r !== m_err) begin miss++; $display("FAIL rand_err i=%0d got=%b exp=%b", i, bus.err_r, m_err); end
`endif
    end
    cycle(0, 0, 0, 0, 0, 4'hF);
  endtask
`ifdef FIFO_MC_ERR_EN
  task automatic test_err();
    for (int i = 0; i < N; i++) cycle(1, 2, 32'h200 + i, 0, 0, 0);
    cycle(1, 2, 32'hBAD, 0, 0, 0);
    vec++;
    if (bus.err_r !== 4'b0100 || bus.level_r[14:10] !== 5'd16) begin
      miss++; $display("FAIL err_set err=%b lvl=%0d exp=0100/16", bus.err_r, bus.level_r[14:10]);
    end
    cycle(0, 0, 0, 1, 2, 0);
    vec++;
    if (got_pop !== 32'h200) begin miss++; $display("FAIL err_head got=%h exp=%h", got_pop, 32'h200); end
    cycle(0, 0, 0, 0, 0, 4'b0100);
    vec++;
    if (bus.err_r !== 4'b0000) begin miss++; $display("FAIL err_clear got=%b exp=0000", bus.err_r); end
  endtask
`endif
  initial begin
    test_reset();
    test_fill_drain();
    test_interleave();
    test_same_cycle();
    test_flush();
    test_random();
`ifdef FIFO_MC_ERR_EN
    test_err();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule

// File: doc/fifo_mc.md
Name: fifo_mc

Overview:
- Parametrised successor to the single-channel FIFO.
- C independent logical FIFOs share one flat storage array of C*N entries of W bits. Each channel owns a fixed partition of N entries.
- One push and one pop per cycle, each steered by a channel index.
- Per-channel empty/full/almost-full flags, per-channel occupancy, per-channel flush.
- Used as a per-queue staging buffer ahead of arbiters and credit schemes.

Parameters:
- W, 32, data width in bits.
- N, 16, entries per channel; power of 2, >= 2 (static assert).
- C, 4, channel count; power of 2, >= 2 (static assert).
- AFULL_TH, 14, almost-full threshold: afull_r[c] is 1 when level >= AFULL_TH; range 1..N (static assert).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- push  in  1  push request.
- push_ch  in  $clog2(C)  push channel index.
- push_data  in  W  push payload.
- pop  in  1  pop request.
- pop_ch  in  $clog2(C)  pop channel index; also selects pop_data.
- pop_data  out  W  head entry of channel pop_ch (combinational).
- flush  in  C  per-channel flush, bit c clears channel c.
- empty_r  out  C  per-channel empty, registered.
- full_r  out  C  per-channel full, registered.
- afull_r  out  C  per-channel almost-full, registered.
- level_r  out  C*($clog2(N)+1)  per-channel occupancy 0..N, packed channel 0 in LSBs, registered.

Behaviour:
- Per-channel state: rd/wr pointers of $clog2(N)+1 bits (wrap bit plus address), plus level.
- Storage address is {ch, ptr.a}. Storage is not reset; only pointers and flags are reset.
- Reset (async assert, synchronous deassert by the integrator):
  - all pointers 0
  - empty_r = all 1s
  - full_r = 0, afull_r = 0, level_r = 0
  - pop_data = X, undefined until first push.
- Accept rules:
  - push_adv = push & ~full_r[push_ch] & ~flush[push_ch]
  - pop_adv = pop & ~empty_r[pop_ch] & ~flush[pop_ch]
- Pointer update, per channel c:
  - flush[c]: rd = wr = 0, level 0.
  - Otherwise rd increments on pop_adv with pop_ch==c, and wr increments on push_adv with push_ch==c.
- Flag updates (all registered from next-state pointers; one-cycle latency from the accepting edge):
  - empty = pointers equal.
  - full = wrap bits differ and addresses equal.
  - level = wr - rd, modulo 2N, in $clog2(N)+1 bits.
  - afull = level >= AFULL_TH.
- Memory write: mem[{push_ch, wr_ptr_r[push_ch].a}] <= push_data on push_adv.
- pop_data = mem[{pop_ch, rd_ptr_r[pop_ch].a}], zero-cycle combinational. Pushed data is visible no earlier than the cycle after its push.
- Simultaneous push and pop:
  - Different channels: fully independent.
  - Same channel, neither empty nor full: both accepted, level unchanged.
  - Same channel, full: the pop is accepted and the push is dropped (full_r is registered); level becomes N-1.
  - Same channel, empty: the push is accepted and the pop is dropped; level becomes 1.
- Wrap-around: pointer addresses roll from N-1 to 0 and the wrap bit toggles. No corruption across the channel partition boundary.
- Flush vs push/pop on the same channel in the same cycle: flush wins and the push data is discarded. Other channels are unaffected.
- Illegal use (push to full, pop of empty) is dropped with no state change and is flagged by libtb2 assertions.
- Invariant: empty_r[c] and full_r[c] are never both set (assertion).

Optional Feature:
- Macro: FIFO_MC_ERR_EN.
- Defined:
  - Adds output port err_r, in C bits, sticky.
  - err_r[c] sets on a push to channel c while full_r[c], or a pop of channel c while empty_r[c], excluding same-cycle flush[c].
  - Cleared by flush[c] or rst; reset value 0.
  - The illegal-use assertions are disabled so the error path can be exercised.
- Undefined: port absent; illegal operations are silently dropped and asserted against.

Test Plan:
- Reset, then idle -> empty_r=4'b1111, full_r=0, afull_r=0, all level_r=0.
- Push 16 words 0x100..0x10F to ch2 -> level_r[2] reaches 14 and afull_r[2]=1 on the edge after the 14th push; full_r[2]=1 after the 16th. Then pop 16 from ch2 -> pop_data 0x100..0x10F in order, empty_r[2]=1. ch0/1/3 untouched.
- Interleave pushes to ch0 (0xA0..) and ch3 (0xB0..) with pops from ch1 (empty) -> no ch1 state change. Per-channel order is preserved on subsequent drains.
- Same-cycle push/pop on ch1 holding 5 entries, for 40 cycles -> level_r[1] stays 5, pointers wrap twice, data sequence intact.
- ch0 holding 8 entries, assert flush=4'b0001 with push to ch0 and pop from ch3 in the same cycle -> ch0 empty with level 0, the push is discarded, and the ch3 pop is accepted.
- With FIFO_MC_ERR_EN: push to full ch2 -> err_r=4'b0100, ch2 contents unchanged. Flush ch2 -> err_r=0.
